// File: rtl/parking_slot_scheduler.sv
// parking_slot_scheduler: per-slot FREE/RESERVED/OCCUPIED tracking, lowest-free-slot grants per zone, reservation expiry, guidance LEDs; optional ZONE_FALLBACK_EN lets a full zone spill into other zones
module parking_slot_scheduler #(
  parameter int NZONE          = 3,
  parameter int SLOTS_PER_ZONE = 2,
  parameter int TIMEOUT        = 30,
  parameter int TW             = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NZONE*SLOTS_PER_ZONE-1:0] occ_n,
  input  logic                            req_valid,
  input  logic [1:0]                      req_zone,
  output logic                            req_ready,
  output logic                            grant_valid,
  output logic [3:0]                      grant_slot,
  output logic [1:0]                      grant_zone,
  output logic                            grant_full,
  output logic                            grant_err,
  output logic [NZONE*SLOTS_PER_ZONE-1:0] led,
  output logic [3:0]                      free_count,
  output logic                            all_full,
  output logic                            intrusion
);
  localparam int NSLOT = NZONE * SLOTS_PER_ZONE;
  typedef enum logic [1:0] {FREE, RESERVED, OCCUPIED} slot_t;
  typedef enum logic [1:0] {IDLE, SEARCH, RESP} fsm_t;
  fsm_t fsm;
  slot_t st [NSLOT];
  logic [TW-1:0] tmr [NSLOT];
  logic [NSLOT-1:0] sync1, sync2, occ, avail, gsel, intr_v;
  logic init, zone_ok, found, hit;
  logic [1:0] zone_q;
  logic [3:0] pick, nfree;
  assign occ = ~sync2;
  assign req_ready = fsm == IDLE;
  assign hit = fsm == SEARCH && zone_ok && found;
  // Sensor synchronizer; left out of reset so occupancy is already settled on the init cycle
  always_ff @(posedge clock) begin
    sync1 <= occ_n;
    sync2 <= sync1;
  end
  // Per-slot availability, free count, grant select and intrusion detection
  always_comb begin
    nfree = 4'd0;
    for (int i = 0; i < NSLOT; i++) begin
      avail[i] = st[i] == FREE && !occ[i];
      gsel[i] = hit && pick == 4'(i);
      intr_v[i] = st[i] == FREE && occ[i] && !init && !gsel[i];
      led[i] = st[i] == RESERVED;
      nfree = nfree + 4'(st[i] == FREE);
    end
  end
  // Lowest available slot in the requested zone, optionally falling back to the lowest anywhere
  always_comb begin
    zone_ok = zone_q != 2'd0 && zone_q <= 2'(NZONE);
    found = 1'b0;
    pick = 4'd0;
    for (int i = NSLOT - 1; i >= 0; i--)
      if (avail[i] && zone_q == 2'(i / SLOTS_PER_ZONE + 1)) begin
        found = 1'b1;
        pick = 4'(i);
      end
`ifdef ZONE_FALLBACK_EN
    if (!found)
      for (int i = NSLOT - 1; i >= 0; i--)
        if (avail[i]) begin
          found = 1'b1;
          pick = 4'(i);
        end
`endif
  end
  // Slot state machines and reservation timers; a grant overrides sensor activity that cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        st[i] <= FREE;
        tmr[i] <= '0;
      end
      init <= 1'b1;
      intrusion <= 1'b0;
    end else begin
      init <= 1'b0;
      intrusion <= |intr_v;
      for (int i = 0; i < NSLOT; i++) begin
        if (gsel[i]) begin
          st[i] <= RESERVED;
          tmr[i] <= '0;
        end else if (st[i] == FREE) begin
          st[i] <= occ[i] ? OCCUPIED : FREE;
        end else if (st[i] == RESERVED) begin
          if (occ[i] || tmr[i] == TW'(TIMEOUT - 1)) begin
            st[i] <= occ[i] ? OCCUPIED : FREE;
            tmr[i] <= '0;
          end else begin
            tmr[i] <= tmr[i] + TW'(tmr[i] != '1);
          end
        end else begin
          st[i] <= occ[i] ? OCCUPIED : FREE;
        end
      end
    end
  end
  // Request FSM with registered grant response and free-slot statistics
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm <= IDLE;
      zone_q <= 2'd0;
      grant_valid <= 1'b0;
      grant_slot <= 4'd0;
      grant_zone <= 2'd0;
      grant_full <= 1'b0;
      grant_err <= 1'b0;
      free_count <= 4'(NSLOT);
      all_full <= 1'b0;
    end else begin
      fsm <= fsm == IDLE ? (req_valid ? SEARCH : IDLE) : fsm == SEARCH ? RESP : IDLE;
      zone_q <= fsm == IDLE && req_valid ? req_zone : zone_q;
      grant_valid <= fsm == SEARCH;
      grant_err <= fsm == SEARCH && !zone_ok;
      grant_full <= fsm == SEARCH && zone_ok && !found;
      grant_slot <= hit ? pick + 4'd1 : 4'd0;
      grant_zone <= hit ? 2'(pick / SLOTS_PER_ZONE + 1) : 2'd0;
      free_count <= nfree;
      all_full <= nfree == 4'd0;
    end
  end
endmodule

// File: tb/tb_parking_slot_scheduler.sv
// tb_parking_slot_scheduler: directed spec scenarios plus random traffic against a slot-level reference model
module tb_parking_slot_scheduler;
  localparam int NS = 6, SPZ = 2, NZ = 3, TO = 30;
  logic clock = 1'b0, reset = 1'b1;
  logic [NS-1:0] occ_n = '1;
  logic req_valid = 1'b0;
  logic [1:0] req_zone = 2'd0;
  logic req_ready, grant_valid, grant_full, grant_err, all_full, intrusion;
  logic [3:0] grant_slot, free_count;
  logic [1:0] grant_zone;
  logic [NS-1:0] led;
  parking_slot_scheduler dut (
    .clock(clock), .reset(reset), .occ_n(occ_n), .req_valid(req_valid), .req_zone(req_zone),
    .req_ready(req_ready), .grant_valid(grant_valid), .grant_slot(grant_slot), .grant_zone(grant_zone),
    .grant_full(grant_full), .grant_err(grant_err), .led(led), .free_count(free_count),
    .all_full(all_full), .intrusion(intrusion)
  );
  always #5 clock = ~clock;
  typedef struct {int cyc; int slot; int zone; bit full; bit err;} grant_t;
  grant_t sbq[$];
  int compared = 0, mismatched = 0, edge_n = 0;
  int m_st[NS], m_exp[NS];
  logic [NS-1:0] m_s1 = '1, m_s2 = '1, e_led = '0;
  bit m_init = 1'b1, e_intr = 1'b0, e_ready = 1'b1;
  int m_phase = 0, m_zone = 0, e_free = NS;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask
  // Reference model: slot states 0=free 1=reserved 2=occupied; reservations expire TO edges after grant
  task automatic model_step();
    logic [NS-1:0] occ;
    int pick, nfree;
    bit intr;
    grant_t g;
    edge_n++;
    occ = ~m_s2;
    m_s2 = m_s1;
    m_s1 = occ_n;
    if (reset) begin
      foreach (m_st[i]) m_st[i] = 0;
      m_init = 1'b1;
      m_phase = 0;
      e_free = NS;
      e_intr = 1'b0;
    end else begin
      nfree = 0;
      foreach (m_st[i]) nfree += int'(m_st[i] == 0);
      e_free = nfree;
      pick = -1;
      if (m_phase == 1) begin
        g = '{edge_n, 0, 0, 1'b0, 1'b0};
        if (m_zone < 1 || m_zone > NZ) g.err = 1'b1;
        else begin
          for (int i = (m_zone - 1) * SPZ; i < m_zone * SPZ && pick < 0; i++)
            if (m_st[i] == 0 && !occ[i]) pick = i;
`ifdef ZONE_FALLBACK_EN
          for (int z = 1; z <= NZ && pick < 0; z++)
            if (z != m_zone)
              for (int i = (z - 1) * SPZ; i < z * SPZ && pick < 0; i++)
                if (m_st[i] == 0 && !occ[i]) pick = i;
`endif
          if (pick < 0) g.full = 1'b1;
          else begin
            g.slot = pick + 1;
            g.zone = pick / SPZ + 1;
          end
        end
        sbq.push_back(g);
      end
      intr = 1'b0;
      for (int i = 0; i < NS; i++) begin
        if (i == pick) begin
          m_st[i] = 1;
          m_exp[i] = edge_n + TO;
        end else if (m_st[i] == 0) begin
          if (occ[i]) begin
            m_st[i] = 2;
            if (!m_init) intr = 1'b1;
          end
        end else if (m_st[i] == 1) begin
          if (occ[i]) m_st[i] = 2;
          else if (edge_n == m_exp[i]) m_st[i] = 0;
        end else if (!occ[i]) m_st[i] = 0;
      end
      e_intr = intr;
      m_init = 1'b0;
      if (m_phase == 0 && req_valid) m_zone = int'(req_zone);
      m_phase = m_phase == 0 ? int'(req_valid) : m_phase == 1 ? 2 : 0;
    end
    foreach (e_led[i]) e_led[i] = m_st[i] == 1;
    e_ready = m_phase == 0;
  endtask
  initial forever begin
    @(posedge clock);
    model_step();
  end
  // Monitor: per-cycle status checks and scoreboard pop on every grant strobe
  initial forever begin
    grant_t g;
    @(negedge clock);
    chk("led", 32'(led), 32'(e_led));
    chk("free_count", 32'(free_count), e_free);
    chk("all_full", 32'(all_full), 32'(e_free == 0));
    chk("intrusion", 32'(intrusion), 32'(e_intr));
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    if (grant_valid) begin
      if (sbq.size() == 0) chk("grant_unexpected", 32'(grant_valid), 0);
      else begin
        g = sbq.pop_front();
        chk("grant_cycle", edge_n, g.cyc);
        chk("grant_slot", 32'(grant_slot), g.slot);
        chk("grant_zone", 32'(grant_zone), g.zone);
        chk("grant_full", 32'(grant_full), 32'(g.full));
        chk("grant_err", 32'(grant_err), 32'(g.err));
      end
    end else chk("grant_idle", {26'd0, grant_slot, grant_zone}, {31'd0, grant_full | grant_err});
  end
  task automatic do_req(input int z);
    int n = 0;
    while (!req_ready && n < 8) begin
      @(negedge clock);
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_zone = 2'(z);
    @(negedge clock);
    req_valid = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    do_req(2);
    @(negedge clock);
    chk("t1_led", 32'(led), 32'b000100);
    chk("t1_slot", 32'(grant_slot), 3);
    @(negedge clock);
    chk("t1_free", 32'(free_count), 5);
    occ_n[2] = 1'b0;
    repeat (4) @(negedge clock);
    chk("t2_led", 32'(led), 0);
    occ_n[2] = 1'b1;
    repeat (4) @(negedge clock);
    do_req(1);
    @(negedge clock);
    chk("t3_led_set", 32'(led), 32'b000001);
    repeat (29) @(negedge clock);
    chk("t3_led_hold", 32'(led[0]), 1);
    @(negedge clock);
    chk("t3_led_drop", 32'(led[0]), 0);
    @(negedge clock);
    chk("t3_free", 32'(free_count), 6);
    occ_n[1:0] = 2'b00;
    repeat (4) @(negedge clock);
    do_req(1);
    @(negedge clock);
`ifdef ZONE_FALLBACK_EN
    chk("t4_fallback_slot", 32'(grant_slot), 3);
`else
    chk("t4_full", 32'(grant_full), 1);
`endif
    occ_n[1:0] = 2'b11;
    repeat (40) @(negedge clock);
    do_req(0);
    @(negedge clock);
    chk("t5_err", 32'(grant_err), 1);
    occ_n[5] = 1'b0;
    repeat (3) @(negedge clock);
    chk("t5_intr", 32'(intrusion), 1);
    @(negedge clock);
    chk("t5_intr_end", 32'(intrusion), 0);
    chk("t5_free", 32'(free_count), 5);
    occ_n[5] = 1'b1;
    repeat (4) @(negedge clock);
    do_req(2);
    reset = 1'b1;
    occ_n[0] = 1'b0;
    repeat (3) @(negedge clock);
    chk("t6_led", 32'(led), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("t6_intr", 32'(intrusion), 0);
    chk("t6_free", 32'(free_count), 5);
    occ_n[0] = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clock);
      if ($urandom_range(0, 19) == 0) occ_n[$urandom_range(0, NS - 1)] ^= 1'b1;
      if (grant_valid && grant_slot != 4'd0 && $urandom_range(0, 1) == 1) occ_n[grant_slot - 4'd1] = 1'b0;
      req_valid = $urandom_range(0, 3) == 0;
      req_zone = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) begin
        req_valid = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
      end
    end
    req_valid = 1'b0;
    repeat (5) @(negedge clock);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
